// File: rtl/pucch_sched.sv
// pucch_sched: round-robin request arbiter and run supervisor
// for the shared pucch symbol generator engine.
module pucch_sched #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 400,
  parameter int CFGW    = 42,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [NREQ*CFGW-1:0] i_req_cfg,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [2:0]           o_pucch_format,
  output logic [3:0]           o_symStart,
  output logic [3:0]           o_nPUCCHSym,
  output logic [1:0]           o_ack,
  output logic [1:0]           o_lenACK,
  output logic                 o_sr,
  output logic                 o_lenSR,
  output logic [3:0]           o_m0,
  output logic [7:0]           o_nslot,
  output logic [9:0]           o_nid,
  output logic [2:0]           o_occi,
  output logic                 o_eng_start,
  input  logic                 i_eng_valid,
  input  logic                 i_eng_done,
  output logic                 o_busy,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [1:0]           o_rsp_status,
  output logic [7:0]           o_rsp_count
);

  localparam int WDW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_START,
    S_RUN,
    S_REPORT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [IDW-1:0]  r_rr;
  logic [IDW-1:0]  r_id;
  logic [CFGW-1:0] r_cfg;
  logic [7:0]      r_exp;
  logic [7:0]      r_cnt;
  logic [WDW-1:0]  r_wd;
  logic [1:0]      r_status;

  logic            w_any;
  logic [IDW-1:0]  w_gnt;
  logic [IDW-1:0]  w_rr_nxt;
  int              w_idx;
  logic            w_bad;
  logic [7:0]      w_exp;
  logic [7:0]      w_cnt_nxt;
  logic            w_to;
  logic            w_cfg_on;
  logic            w_f0ok;
  logic            w_f1ok;

  logic [2:0] w_fmt;
  logic [3:0] w_sym0;
  logic [3:0] w_nsym;
  logic [1:0] w_lena;

  assign w_fmt  = r_cfg[41:39];
  assign w_sym0 = r_cfg[38:35];
  assign w_nsym = r_cfg[34:31];
  assign w_lena = r_cfg[28:27];

  // first valid requester at or after the round-robin pointer
  always_comb begin
    w_any = 1'b0;
    w_gnt = '0;
    w_idx = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = int'(r_rr) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_any && i_req_valid[w_idx]) begin
        w_any = 1'b1;
        w_gnt = IDW'(w_idx);
      end
    end
  end

  assign w_rr_nxt = (int'(w_gnt) == NREQ - 1) ?
                    '0 : w_gnt + 1'b1;

  assign w_f0ok = (w_fmt == 3'd0) &&
                  (w_nsym >= 4'd1) && (w_nsym <= 4'd2);
  assign w_f1ok = (w_fmt == 3'd1) &&
                  (w_nsym >= 4'd4) && (w_nsym <= 4'd14);

  always_comb begin
    w_bad = 1'b1;
    w_exp = '0;
    unique case (1'b1)
      w_f0ok: begin
        w_bad = 1'b0;
        w_exp = {4'd0, w_nsym} * 8'd12;
      end
      w_f1ok: begin
        w_bad = 1'b0;
        w_exp = {5'd0, w_nsym[3:1]} * 8'd12;
      end
      default: w_bad = 1'b1;
    endcase
    if (({1'b0, w_sym0} + {1'b0, w_nsym}) > 5'd14 ||
        w_lena > 2'd2)
      w_bad = 1'b1;
  end

  // a valid coincident with done still counts
  assign w_cnt_nxt = (i_eng_valid && r_cnt != 8'hFF) ?
                     r_cnt + 8'd1 : r_cnt;
  assign w_to = (r_wd == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_any) w_next = S_CHECK;
      S_CHECK:  w_next = w_bad ? S_REPORT : S_START;
      S_START:  w_next = S_RUN;
      S_RUN:    if (i_eng_done || w_to) w_next = S_REPORT;
      S_REPORT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr     <= '0;
      r_id     <= '0;
      r_cfg    <= '0;
      r_exp    <= '0;
      r_cnt    <= '0;
      r_wd     <= '0;
      r_status <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_cfg    <= i_req_cfg[int'(w_gnt)*CFGW +: CFGW];
            r_id     <= w_gnt;
            r_rr     <= w_rr_nxt;
            r_cnt    <= '0;
            r_status <= 2'd0;
          end
        end
        S_CHECK: begin
          r_exp <= w_exp;
          if (w_bad) r_status <= 2'd1;
        end
        S_START: begin
          r_cnt <= '0;
          r_wd  <= '0;
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          if (!w_to) r_wd <= r_wd + 1'b1;
          if (i_eng_done)
            r_status <= (w_cnt_nxt == r_exp) ? 2'd0 : 2'd2;
          else if (w_to)
            r_status <= 2'd3;
        end
        default: ;
      endcase
    end
  end

  assign w_cfg_on = (r_state == S_START) ||
                    (r_state == S_RUN) ||
                    (r_state == S_REPORT);

  always_comb begin
    o_req_ready  = '0;
    o_eng_start  = 1'b0;
    o_busy       = (r_state != S_IDLE);
    o_rsp_valid  = 1'b0;
    o_rsp_id     = '0;
    o_rsp_status = '0;
    o_rsp_count  = '0;
    unique case (r_state)
      S_IDLE:
        if (w_any) o_req_ready = NREQ'(1) << w_gnt;
      S_START:
        o_eng_start = 1'b1;
      S_REPORT: begin
        o_rsp_valid  = 1'b1;
        o_rsp_id     = r_id;
        o_rsp_status = r_status;
        o_rsp_count  = r_cnt;
      end
      default: ;
    endcase
  end

  assign {o_pucch_format, o_symStart, o_nPUCCHSym,
          o_ack, o_lenACK, o_sr, o_lenSR, o_m0,
          o_nslot, o_nid, o_occi} =
         w_cfg_on ? r_cfg : '0;

endmodule

// File: tb/tb_pucch_sched.sv
// tb_pucch_sched: directed stimulus with an event-time
// model of grants, starts and responses checked each cycle.
module tb_pucch_sched;

  localparam int NREQ    = 2;
  localparam int TIMEOUT = 400;
  localparam int CFGW    = 42;
  localparam int IDW     = $clog2(NREQ);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NREQ-1:0]      req_valid = '0;
  logic [CFGW-1:0]      cfg_arr[NREQ];
  logic [NREQ*CFGW-1:0] req_cfg;
  logic [NREQ-1:0]      o_req_ready;
  logic [2:0]           o_pucch_format;
  logic [3:0]           o_symStart, o_nPUCCHSym, o_m0;
  logic [1:0]           o_ack, o_lenACK;
  logic                 o_sr, o_lenSR;
  logic [7:0]           o_nslot;
  logic [9:0]           o_nid;
  logic [2:0]           o_occi;
  logic                 o_eng_start;
  logic                 eng_valid = 1'b0;
  logic                 eng_done  = 1'b0;
  logic                 o_busy, o_rsp_valid;
  logic [IDW-1:0]       o_rsp_id;
  logic [1:0]           o_rsp_status;
  logic [7:0]           o_rsp_count;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cfg
    assign req_cfg[gi*CFGW +: CFGW] = cfg_arr[gi];
  end

  pucch_sched #(
    .NREQ(NREQ), .TIMEOUT(TIMEOUT), .CFGW(CFGW)
  ) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(req_valid), .i_req_cfg(req_cfg),
    .o_req_ready(o_req_ready),
    .o_pucch_format(o_pucch_format),
    .o_symStart(o_symStart), .o_nPUCCHSym(o_nPUCCHSym),
    .o_ack(o_ack), .o_lenACK(o_lenACK),
    .o_sr(o_sr), .o_lenSR(o_lenSR), .o_m0(o_m0),
    .o_nslot(o_nslot), .o_nid(o_nid), .o_occi(o_occi),
    .o_eng_start(o_eng_start),
    .i_eng_valid(eng_valid), .i_eng_done(eng_done),
    .o_busy(o_busy), .o_rsp_valid(o_rsp_valid),
    .o_rsp_id(o_rsp_id), .o_rsp_status(o_rsp_status),
    .o_rsp_count(o_rsp_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  function automatic logic [CFGW-1:0] mk(
    input int fmt, input int s0, input int ns,
    input int ack, input int lena, input int sr,
    input int lsr, input int m0, input int nslot,
    input int nid, input int occi);
    return {3'(fmt), 4'(s0), 4'(ns), 2'(ack), 2'(lena),
            1'(sr), 1'(lsr), 4'(m0), 8'(nslot),
            10'(nid), 3'(occi)};
  endfunction

  // expected outcome of a request from the field rules alone
  function automatic void predict(
    input logic [CFGW-1:0] c, input int nv, input bit dn,
    output bit bad, output int st, output int cnt);
    int fmt, s0, ns, lena, expn;
    fmt  = int'(c[41:39]);
    s0   = int'(c[38:35]);
    ns   = int'(c[34:31]);
    lena = int'(c[28:27]);
    bad  = 1'b0;
    expn = 0;
    if (fmt == 0 && ns >= 1 && ns <= 2) expn = 12 * ns;
    else if (fmt == 1 && ns >= 4 && ns <= 14)
      expn = 12 * (ns / 2);
    else bad = 1'b1;
    if (s0 + ns > 14 || lena > 2) bad = 1'b1;
    cnt = (nv > 255) ? 255 : nv;
    if (bad) begin
      st = 1;
      cnt = 0;
    end else if (!dn) st = 3;
    else st = (cnt == expn) ? 0 : 2;
  endfunction

  int plan_nv[NREQ];
  bit plan_done[NREQ];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int m_rr = 0, m_gnt_cyc = -1, m_rsp_cyc = -1;
  int m_start_cyc = -1, m_id = 0, m_st = 0, m_cnt = 0;
  bit m_bad;
  logic [CFGW-1:0] m_cfg;
  int n_start = 0, n_rsp = 0, n_gnt = 0, n_multi = 0;
  int gnt_log[$];
  int last_gnt_cyc = 0, last_rsp_cyc = 0;
  int rsp_id = 0, rsp_st = 0, rsp_cnt = 0;
  bit c_idle;
  int c_g, c_idx;
  logic [NREQ-1:0] c_er;

  always @(negedge clk) begin
    if (rst) begin
      m_rr = 0;
      m_rsp_cyc = -1;
      m_start_cyc = -1;
      m_gnt_cyc = -1;
    end else begin
      c_idle = (cyc > m_rsp_cyc);
      c_g = -1;
      c_er = '0;
      if (c_idle)
        for (int k = 0; k < NREQ; k++) begin
          c_idx = (m_rr + k) % NREQ;
          if (c_g < 0 && req_valid[c_idx]) c_g = c_idx;
        end
      if (c_g >= 0) c_er[c_g] = 1'b1;
      if ($countones(o_req_ready) > 1) n_multi++;
      chk("req_ready", 64'(o_req_ready), 64'(c_er));
      chk("eng_start", 64'(o_eng_start),
          64'(cyc == m_start_cyc));
      chk("rsp_valid", 64'(o_rsp_valid),
          64'(cyc == m_rsp_cyc));
      chk("busy", 64'(o_busy), 64'(!c_idle));
      if (o_eng_start) n_start++;
      if (o_rsp_valid) begin
        n_rsp++;
        last_rsp_cyc = cyc;
        rsp_id  = int'(o_rsp_id);
        rsp_st  = int'(o_rsp_status);
        rsp_cnt = int'(o_rsp_count);
      end
      if (cyc == m_rsp_cyc) begin
        chk("rsp_id", 64'(o_rsp_id), 64'(m_id));
        chk("rsp_status", 64'(o_rsp_status), 64'(m_st));
        chk("rsp_count", 64'(o_rsp_count), 64'(m_cnt));
      end
      if (m_start_cyc >= 0 && cyc >= m_start_cyc &&
          cyc <= m_rsp_cyc)
        chk("cfg_out",
            64'({o_pucch_format, o_symStart, o_nPUCCHSym,
                 o_ack, o_lenACK, o_sr, o_lenSR, o_m0,
                 o_nslot, o_nid, o_occi}),
            64'(m_cfg));
      if (c_g >= 0) begin
        m_gnt_cyc = cyc;
        m_id  = c_g;
        m_cfg = cfg_arr[c_g];
        m_rr  = (c_g + 1) % NREQ;
        predict(m_cfg, plan_nv[c_g], plan_done[c_g],
                m_bad, m_st, m_cnt);
        if (m_bad) begin
          m_start_cyc = -1;
          m_rsp_cyc = cyc + 2;
        end else begin
          m_start_cyc = cyc + 2;
          m_rsp_cyc = plan_done[c_g] ?
                      cyc + 3 + plan_nv[c_g] :
                      cyc + 3 + TIMEOUT;
        end
        n_gnt++;
        last_gnt_cyc = cyc;
        gnt_log.push_back(c_g);
      end
    end
  end

  // engine stand-in: nv valids, done on the last one
  initial begin
    int nv;
    bit dn;
    forever begin
      @(negedge clk);
      if (!rst && o_eng_start) begin
        nv = plan_nv[m_id];
        dn = plan_done[m_id];
        for (int k = 0; k < nv; k++) begin
          @(posedge clk);
          #1;
          if (rst) break;
          eng_valid = 1'b1;
          eng_done  = dn && (k == nv - 1);
        end
        @(posedge clk);
        #1;
        eng_valid = 1'b0;
        eng_done  = 1'b0;
      end
    end
  end

  task automatic wait_gnt(input int target);
    int k = 0;
    while (n_gnt < target && k < 2000) begin
      @(posedge clk);
      k++;
    end
    chk("grant_wait", 64'(n_gnt >= target), 64'd1);
    #1;
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (n_rsp < target && k < TIMEOUT + 2000) begin
      @(posedge clk);
      k++;
    end
    chk("rsp_wait", 64'(n_rsp >= target), 64'd1);
    #1;
  endtask

  task automatic do_req(input int id,
                        input logic [CFGW-1:0] c,
                        input int nv, input bit dn);
    int g0, r0;
    cfg_arr[id]   = c;
    plan_nv[id]   = nv;
    plan_done[id] = dn;
    g0 = n_gnt;
    r0 = n_rsp;
    @(posedge clk);
    #1;
    req_valid[id] = 1'b1;
    wait_gnt(g0 + 1);
    req_valid[id] = 1'b0;
    wait_rsp(r0 + 1);
  endtask

  logic [CFGW-1:0] c_f0, c_f1;
  int s0, r0, g0;

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      cfg_arr[i] = '0;
      plan_nv[i] = 0;
      plan_done[i] = 1'b0;
    end
    c_f0 = mk(0, 4, 2, 2, 2, 1, 1, 5, 3, 512, 0);
    c_f1 = mk(1, 4, 7, 2, 2, 1, 1, 5, 3, 512, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_start", 64'(o_eng_start), 64'd0);
    chk("rst_rsp", 64'({o_rsp_valid, o_rsp_id,
        o_rsp_status, o_rsp_count}), 64'd0);
    chk("rst_cfg", 64'({o_pucch_format, o_symStart,
        o_nPUCCHSym, o_nslot, o_nid}), 64'd0);
    rst = 1'b0;

    s0 = n_start;
    do_req(0, c_f0, 24, 1'b1);
    chk("f0_status", 64'(rsp_st), 64'd0);
    chk("f0_count", 64'(rsp_cnt), 64'd24);
    chk("f0_id", 64'(rsp_id), 64'd0);
    chk("f0_starts", 64'(n_start - s0), 64'd1);
    chk("f0_latency", 64'(last_rsp_cyc - last_gnt_cyc),
        64'd27);

    s0 = n_start;
    do_req(1, c_f1, 36, 1'b1);
    chk("f1_status", 64'(rsp_st), 64'd0);
    chk("f1_count", 64'(rsp_cnt), 64'd36);
    chk("f1_id", 64'(rsp_id), 64'd1);
    chk("f1_starts", 64'(n_start - s0), 64'd1);

    cfg_arr[0] = c_f0;
    cfg_arr[1] = c_f0;
    plan_nv[0] = 24;
    plan_nv[1] = 24;
    plan_done[0] = 1'b1;
    plan_done[1] = 1'b1;
    g0 = n_gnt;
    r0 = n_rsp;
    @(posedge clk);
    #1;
    req_valid = '1;
    wait_gnt(g0 + 4);
    req_valid = '0;
    wait_rsp(r0 + 4);
    chk("rr_0", 64'(gnt_log[g0]), 64'd0);
    chk("rr_1", 64'(gnt_log[g0 + 1]), 64'd1);
    chk("rr_2", 64'(gnt_log[g0 + 2]), 64'd0);
    chk("rr_3", 64'(gnt_log[g0 + 3]), 64'd1);
    chk("ready_onehot", 64'(n_multi), 64'd0);

    s0 = n_start;
    do_req(0, mk(0, 4, 3, 2, 2, 1, 1, 5, 3, 512, 0),
           24, 1'b1);
    chk("bad_ns_status", 64'(rsp_st), 64'd1);
    chk("bad_ns_lat", 64'(last_rsp_cyc - last_gnt_cyc),
        64'd2);
    do_req(0, mk(2, 4, 2, 2, 2, 1, 1, 5, 3, 512, 0),
           24, 1'b1);
    chk("bad_fmt_status", 64'(rsp_st), 64'd1);
    chk("bad_fmt_lat", 64'(last_rsp_cyc - last_gnt_cyc),
        64'd2);
    do_req(1, mk(1, 12, 4, 2, 2, 1, 1, 5, 3, 512, 0),
           24, 1'b1);
    chk("bad_sym_status", 64'(rsp_st), 64'd1);
    chk("bad_sym_id", 64'(rsp_id), 64'd1);
    chk("bad_starts", 64'(n_start - s0), 64'd0);

    do_req(0, c_f0, 20, 1'b1);
    chk("short_status", 64'(rsp_st), 64'd2);
    chk("short_count", 64'(rsp_cnt), 64'd20);

    do_req(0, c_f0, 5, 1'b0);
    chk("to_status", 64'(rsp_st), 64'd3);
    chk("to_count", 64'(rsp_cnt), 64'd5);
    chk("to_latency", 64'(last_rsp_cyc - last_gnt_cyc),
        64'(TIMEOUT + 3));

    cfg_arr[1] = c_f1;
    plan_nv[1] = 36;
    plan_done[1] = 1'b1;
    g0 = n_gnt;
    r0 = n_rsp;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b1;
    wait_gnt(g0 + 1);
    req_valid[1] = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", 64'(o_busy), 64'd0);
    chk("arst_start", 64'(o_eng_start), 64'd0);
    chk("arst_rsp", 64'(o_rsp_valid), 64'd0);
    chk("arst_cfg", 64'({o_pucch_format, o_symStart,
        o_nPUCCHSym, o_ack, o_lenACK, o_sr, o_lenSR,
        o_m0, o_nslot, o_nid, o_occi}), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    chk("arst_no_rsp", 64'(n_rsp - r0), 64'd0);

    do_req(0, c_f0, 24, 1'b1);
    chk("post_status", 64'(rsp_st), 64'd0);
    chk("post_count", 64'(rsp_cnt), 64'd24);
    chk("post_id", 64'(rsp_id), 64'd0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=%0d required=0",
             cyc);
    $fatal(1, "bench timeout");
  end

endmodule
